// File: rtl/cp_pkg.sv
// Shared definitions for the cyclic-prefix inserter: default sizes, read FSM encoding, index width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cp_pkg;

    localparam int FFT_LEN_DEF = 16;
    localparam int CP_LEN_DEF  = 2;
    localparam int W_DEF       = 32;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_CP   = 2'd1,
        R_BODY = 2'd2
    } rd_state_t;

    // Bits needed to index 0..value-1 (value is a power of two here).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/cp_frame_buffer.sv
// Two-bank sample store (bank = address MSB) with one write port, one registered read port, per-bank full flags.
// Latency: read data appears one cycle after rd_en; full flags update one cycle after set/clear.
// Backpressure: none internally; the owner only writes non-full banks and reads full ones.
//
// Ports:
//   aclk, reset          clock, synchronous active-high reset (clears read register and full flags)
//   wr_en/wr_addr/wr_data write port, address = {bank, index}
//   rd_en/rd_addr/rd_data registered read port; rd_data holds while rd_en is low
//   set_full/clr_full     per-bank flag set/clear strobes
//   full                  per-bank full flags
module cp_frame_buffer
    import cp_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int W       = W_DEF
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [clog2(FFT_LEN):0] wr_addr,
    input  logic [W-1:0]            wr_data,
    input  logic                    rd_en,
    input  logic [clog2(FFT_LEN):0] rd_addr,
    output logic [W-1:0]            rd_data,
    input  logic [1:0]              set_full,
    input  logic [1:0]              clr_full,
    output logic [1:0]              full
);

    localparam int DEPTH = 2 * FFT_LEN;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the output data register of the inserter,
    // so it must hold its value whenever the sink is stalling.
    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Set and clear never target the same bank in one cycle: set applies to the
    // bank being written (not full), clear to the bank being read (full).
    always_ff @(posedge aclk) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= (full | set_full) & ~clr_full;
        end
    end

endmodule

// File: rtl/cp_inserter.sv
// OFDM cyclic-prefix inserter: emits last CP_LEN samples of each frame, then the whole frame, via a ping-pong buffer.
// Latency: first prefix sample valid 2 cycles after the edge accepting the last input sample of a frame.
// Backpressure: s_dready low while the current write bank is full; output holds stable while m_dready is low.
//
// Ports:
//   aclk, reset                 clock, synchronous active-high reset
//   s_data_in/s_dvalid/s_dready input sample stream {re[15:0], im[15:0]}
//   s_dlast                     end-of-frame marker, only checked against the beat count
//   m_data_out/m_dvalid/m_dready/m_dlast  output stream, m_dlast on the final beat of CP+frame
//   frame_err                   sticky flag: s_dlast disagreed with the beat count
//   m_frame_index               completed output frames, wraps at 1024
module cp_inserter
    import cp_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int CP_LEN  = CP_LEN_DEF,
    parameter int W       = W_DEF
) (
    input  logic         aclk,
    input  logic         reset,
    input  logic [W-1:0] s_data_in,
    input  logic         s_dvalid,
    output logic         s_dready,
    input  logic         s_dlast,
    output logic [W-1:0] m_data_out,
    output logic         m_dvalid,
    input  logic         m_dready,
    output logic         m_dlast,
    output logic         frame_err,
    output logic [9:0]   m_frame_index
);

    localparam int IDX_W = clog2(FFT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FFT_LEN - 1);
    // Where a frame's readout starts: inside the tail for the prefix, or at 0 with no prefix.
    localparam rd_state_t        START_ST  = (CP_LEN == 0) ? R_BODY : R_CP;
    localparam logic [IDX_W-1:0] START_IDX = (CP_LEN == 0) ? '0 : IDX_W'(FFT_LEN - CP_LEN);

    // Write side state
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_fire;
    logic             wr_last;

    // Read side state
    rd_state_t        rd_state;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_load;
    logic             rd_last;
    logic             out_free;

    logic [1:0]       full;
    logic [1:0]       set_full;
    logic [1:0]       clr_full;

    assign s_dready = !reset && !full[wr_bank];
    assign wr_fire  = s_dvalid && s_dready;
    assign wr_last  = (wr_idx == IDX_LAST);

    // The output register can take a new beat when empty or being drained this edge.
    assign out_free = !m_dvalid || m_dready;
    assign rd_load  = (rd_state != R_IDLE) && out_free;
    assign rd_last  = (rd_state == R_BODY) && (rd_idx == IDX_LAST);

    // The bank is released as soon as its last beat moves into the output
    // register; the data is safe there, and this lets the writer restart early.
    always_comb begin
        set_full = 2'b00;
        clr_full = 2'b00;
        if (wr_fire && wr_last) begin
            set_full[wr_bank] = 1'b1;
        end
        if (rd_load && rd_last) begin
            clr_full[rd_bank] = 1'b1;
        end
    end

    cp_frame_buffer #(
        .FFT_LEN (FFT_LEN),
        .W       (W)
    ) u_buf (
        .aclk     (aclk),
        .reset    (reset),
        .wr_en    (wr_fire),
        .wr_addr  ({wr_bank, wr_idx}),
        .wr_data  (s_data_in),
        .rd_en    (rd_load),
        .rd_addr  ({rd_bank, rd_idx}),
        .rd_data  (m_data_out),
        .set_full (set_full),
        .clr_full (clr_full),
        .full     (full)
    );

    // Write counter and framing check. Data is stored even when s_dlast is wrong.
    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            frame_err <= 1'b0;
        end else if (wr_fire) begin
            if (s_dlast != wr_last) begin
                frame_err <= 1'b1;
            end
            if (wr_last) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Read FSM plus output valid/last registers (data register lives in the buffer).
    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_state      <= R_IDLE;
            rd_bank       <= 1'b0;
            rd_idx        <= '0;
            m_dvalid      <= 1'b0;
            m_dlast       <= 1'b0;
            m_frame_index <= '0;
        end else begin
            if (m_dvalid && m_dready && m_dlast) begin
                m_frame_index <= m_frame_index + 10'd1;
            end

            if (rd_load) begin
                m_dvalid <= 1'b1;
                m_dlast  <= rd_last;
            end else if (out_free) begin
                m_dvalid <= 1'b0;
                m_dlast  <= 1'b0;
            end

            case (rd_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state <= START_ST;
                        rd_idx   <= START_IDX;
                    end
                end
                R_CP: begin
                    if (rd_load) begin
                        if (rd_idx == IDX_LAST) begin
                            rd_state <= R_BODY;
                            rd_idx   <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                R_BODY: begin
                    if (rd_load) begin
                        if (rd_last) begin
                            rd_bank <= ~rd_bank;
                            // Chain straight into the next frame if it is already waiting.
                            if (full[~rd_bank]) begin
                                rd_state <= START_ST;
                                rd_idx   <= START_IDX;
                            end else begin
                                rd_state <= R_IDLE;
                                rd_idx   <= '0;
                            end
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                    rd_idx   <= '0;
                end
            endcase
        end
    end

endmodule
